bram_mixed_reader: RTL and testbench

BRAM_MIXED_READER -- requirements
Module: bram_mixed_reader

---
 rtl/bram_mixed_reader.sv | 117 +++++++++++
 tb/tb_bram_mixed_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_mixed_reader.sv
// bram_mixed_reader: reads wide BRAM words and streams their narrow lanes, lane 0 first.
// Define BRAM_MIXED_READER_PREFETCH_EN to prefetch the next word for gapless output.
module bram_mixed_reader #(
    parameter int DATA_WIDTH_A = 8,
    parameter int ADDR_WIDTH_A = 10,
    parameter int ADDR_WIDTH_B = 8,
    localparam int RATIO = 1 << (ADDR_WIDTH_A - ADDR_WIDTH_B),
    localparam int DATA_WIDTH_B = DATA_WIDTH_A * RATIO
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic [ADDR_WIDTH_B-1:0] BASE,
    input  logic [ADDR_WIDTH_B:0]   COUNT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [ADDR_WIDTH_B-1:0] RAM_ADDR,
    input  logic [DATA_WIDTH_B-1:0] RAM_DO,
    output logic [DATA_WIDTH_A-1:0] OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    OUT_LAST
);
`ifdef BRAM_MIXED_READER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    localparam int LW = (ADDR_WIDTH_A > ADDR_WIDTH_B) ? ADDR_WIDTH_A - ADDR_WIDTH_B : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
    localparam logic [ADDR_WIDTH_B:0] ONE = 1;
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, EMIT = 3'd3, FIN = 3'd4;
    logic [2:0]              state;
    logic [ADDR_WIDTH_B-1:0] addr;
    logic [ADDR_WIDTH_B:0]   rem;
    logic [LW-1:0]           lane;
    logic [DATA_WIDTH_B-1:0] word, nxt;
    logic                    nxt_valid, pf_pending;
    logic                    xfer, lane_end, word_done, issue;
    always_comb begin
        OUT_VALID = state == EMIT;
        BUSY      = state != IDLE;
        DONE      = state == FIN;
        xfer      = OUT_VALID && OUT_READY;
        lane_end  = lane == LAST_LANE;
        word_done = xfer && lane_end;
        OUT_LAST  = OUT_VALID && lane_end && rem == ONE;
        OUT_DATA  = word[lane*DATA_WIDTH_A +: DATA_WIDTH_A];
        // at most one word in flight beyond the one being emitted
        issue     = PF && OUT_VALID && rem > ONE && !nxt_valid && !pf_pending && !word_done;
        RAM_ADDR  = issue ? addr + ADDR_WIDTH_B'(1) : addr;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            addr       <= '0;
            rem        <= '0;
            lane       <= '0;
            word       <= '0;
            nxt        <= '0;
            nxt_valid  <= 1'b0;
            pf_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    if (COUNT != '0) begin
                        addr  <= BASE;
                        rem   <= COUNT;
                        state <= FETCH;
                    end else begin
                        state <= FIN;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    word  <= RAM_DO;
                    lane  <= '0;
                    state <= EMIT;
                end
                EMIT: begin
                    if (issue) begin
                        addr       <= addr + ADDR_WIDTH_B'(1);
                        pf_pending <= 1'b1;
                    end
                    if (pf_pending) begin
                        pf_pending <= 1'b0;
                        if (!word_done) begin
                            nxt       <= RAM_DO;
                            nxt_valid <= 1'b1;
                        end
                    end
                    if (xfer) lane <= lane_end ? '0 : lane + LW'(1);
                    if (word_done) begin
                        rem <= rem - ONE;
                        if (rem == ONE) begin
                            state <= FIN;
                        end else if (nxt_valid) begin
                            word      <= nxt;
                            nxt_valid <= 1'b0;
                        end else if (pf_pending) begin
                            word <= RAM_DO;
                        end else begin
                            addr  <= addr + ADDR_WIDTH_B'(1);
                            state <= FETCH;
                        end
                    end
                end
                FIN: begin
                    nxt_valid  <= 1'b0;
                    pf_pending <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_mixed_reader.sv
// tb_bram_mixed_reader: random and directed commands checked against a queue model of the expected element stream.
module tb_bram_mixed_reader;
    localparam int AWB = 8, DWB = 32, DEPTH = 256;
`ifdef BRAM_MIXED_READER_PREFETCH_EN
    localparam int SPAN = 11;
`else
    localparam int SPAN = 15;
`endif
    logic CLK = 0, RST_N = 0, START = 0, OUT_READY = 0;
    logic [AWB-1:0] BASE = 0;
    logic [AWB:0] COUNT = 0;
    logic BUSY, DONE, OUT_VALID, OUT_LAST;
    logic [AWB-1:0] RAM_ADDR;
    logic [DWB-1:0] RAM_DO;
    logic [7:0] OUT_DATA;
    logic [DWB-1:0] mem [DEPTH];

    bram_mixed_reader dut (.CLK(CLK), .RST_N(RST_N), .START(START), .BASE(BASE), .COUNT(COUNT),
        .BUSY(BUSY), .DONE(DONE), .RAM_ADDR(RAM_ADDR), .RAM_DO(RAM_DO), .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST));

    always #5 CLK = ~CLK;
    always @(posedge CLK) RAM_DO <= mem[RAM_ADDR];
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0, passes = 0;
    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    logic [7:0] exp_d[$], got_d[$];
    bit exp_l[$], got_l[$];
    int got_c[$];
    logic [AWB-1:0] addr_log[$];
    bit done_exp = 0, prev_stall = 0, prev_last, el;
    logic [7:0] prev_data, ed;
    logic [AWB-1:0] ma;
    logic [DWB-1:0] mw;
    int busy_cycles = 0, valid_cycles = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            exp_d.delete(); exp_l.delete();
            done_exp = 0; prev_stall = 0;
        end else begin
            chk_eq("done", DONE, done_exp);
            chk_eq("busy", BUSY, (exp_d.size() != 0) || done_exp);
            if (prev_stall) begin
                chk_eq("stall_valid", OUT_VALID, 1);
                chk_eq("stall_data", OUT_DATA, prev_data);
                chk_eq("stall_last", OUT_LAST, prev_last);
            end
            if (BUSY) busy_cycles++;
            if (OUT_VALID) valid_cycles++;
            if (DONE) begin done_cnt++; done_cyc = cyc; end
            if (BUSY && (addr_log.size() == 0 || addr_log[$] != RAM_ADDR)) addr_log.push_back(RAM_ADDR);
            done_exp = 0;
            if (OUT_VALID && OUT_READY) begin
                if (exp_d.size() == 0) chk_eq("extra_element", OUT_DATA, 'x);
                else begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    chk_eq("data", OUT_DATA, ed);
                    chk_eq("last", OUT_LAST, el);
                    done_exp = el;
                end
                got_d.push_back(OUT_DATA); got_l.push_back(OUT_LAST); got_c.push_back(cyc);
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data = OUT_DATA;
            prev_last = OUT_LAST;
            if (START && !BUSY) begin
                if (COUNT == 0) done_exp = 1;
                for (int w = 0; w < int'(COUNT); w++) begin
                    ma = BASE + AWB'(w);
                    mw = mem[ma];
                    for (int j = 0; j < 4; j++) begin
                        exp_d.push_back(mw[j*8 +: 8]);
                        exp_l.push_back(w == int'(COUNT) - 1 && j == 3);
                    end
                end
            end
        end
    end

    int rmode = 0;
    bit pat [4] = '{1, 0, 0, 1};

    task automatic step(); @(posedge CLK); #1; endtask
    task automatic clear_log();
        got_d.delete(); got_l.delete(); got_c.delete(); addr_log.delete();
        busy_cycles = 0; valid_cycles = 0; done_cnt = 0;
    endtask
    task automatic issue(input logic [AWB-1:0] b, input logic [AWB:0] c);
        START = 1; BASE = b; COUNT = c; start_cyc = cyc;
        step();
        START = 0;
    endtask
    task automatic drive_cycle(input int k);
        OUT_READY = rmode == 0 ? 1'b1 : rmode == 1 ? pat[k%4] : ($urandom % 4 != 0);
        START = rmode == 2 && BUSY && ($urandom % 5 == 0);
        BASE = AWB'($urandom); COUNT = (AWB+1)'($urandom_range(0, 6));
    endtask
    task automatic wait_idle(input int budget);
        int n = 0;
        while ((BUSY || exp_d.size() != 0 || done_exp) && n < budget) begin
            drive_cycle(n);
            step();
            n++;
        end
        START = 0;
        if (n >= budget) chk_eq("timeout", n, 0);
    endtask
    task automatic check_reset_outputs();
        chk_eq("rst_busy", BUSY, 0); chk_eq("rst_done", DONE, 0);
        chk_eq("rst_valid", OUT_VALID, 0); chk_eq("rst_last", OUT_LAST, 0);
        chk_eq("rst_data", OUT_DATA, 0); chk_eq("rst_addr", RAM_ADDR, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[5] = 32'h44332211; mem[255] = 32'hA3A2A1A0; mem[0] = 32'hB3B2B1B0;
        repeat (3) step();
        check_reset_outputs();
        RST_N = 1;
        step();
        // basic single-word command
        clear_log(); rmode = 0; OUT_READY = 1;
        issue(5, 1); wait_idle(50);
        chk_eq("t32_count", got_d.size(), 4);
        if (got_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk_eq("t32_data", got_d[i], 8'h11 * (i + 1));
                chk_eq("t32_last", got_l[i], i == 3);
            end
            chk_eq("t32_latency", got_c[0] - start_cyc, 3);
            chk_eq("t32_done_cyc", done_cyc, got_c[3] + 1);
        end
        chk_eq("t32_done_cnt", done_cnt, 1);
        // zero-length command
        clear_log();
        issue(9, 0); wait_idle(20);
        chk_eq("t33_busy_cycles", busy_cycles, 1);
        chk_eq("t33_valid_cycles", valid_cycles, 0);
        chk_eq("t33_done_cnt", done_cnt, 1);
        chk_eq("t33_done_cyc", done_cyc - start_cyc, 1);
        // address wrap
        clear_log();
        issue(255, 2); wait_idle(60);
        chk_eq("t34_count", got_d.size(), 8);
        if (got_d.size() == 8)
            for (int i = 0; i < 8; i++) chk_eq("t34_data", got_d[i], i < 4 ? 8'hA0 + i : 8'hB0 + i - 4);
        chk_eq("t34_addr_n", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk_eq("t34_addr0", addr_log[0], 255);
            chk_eq("t34_addr1", addr_log[1], 0);
        end
        // back-pressure pattern, then throughput with ready held
        clear_log(); rmode = 1;
        issue(20, 3); wait_idle(200);
        chk_eq("t35_count", got_d.size(), 12);
        chk_eq("t35_done_cnt", done_cnt, 1);
        clear_log(); rmode = 0; OUT_READY = 1;
        issue(40, 3); wait_idle(100);
        chk_eq("t35_valid_cycles", valid_cycles, 12);
        if (got_c.size() == 12) chk_eq("t35_span", got_c[11] - got_c[0], SPAN);
        else chk_eq("t35_count2", got_c.size(), 12);
        // reset mid-command
        clear_log(); OUT_READY = 1;
        issue(100, 2);
        for (int n = 0; n < 20 && got_d.size() < 2; n++) step();
        OUT_READY = 0; RST_N = 0;
        step();
        RST_N = 1;
        check_reset_outputs();
        OUT_READY = 1;
        repeat (4) step();
        chk_eq("t36_no_done", done_cnt, 0);
        clear_log();
        issue(0, 1); wait_idle(50);
        chk_eq("t36_count", got_d.size(), 4);
        if (got_d.size() == 4)
            for (int i = 0; i < 4; i++) chk_eq("t36_data", got_d[i], 8'hB0 + i);
        chk_eq("t36_done_cnt", done_cnt, 1);
        // randomized commands with back-pressure, ignored STARTs and occasional aborts
        rmode = 2;
        for (int k = 0; k < 40; k++) begin
            issue(AWB'($urandom), (AWB+1)'($urandom_range(0, 6)));
            if (k % 8 == 5) begin
                repeat ($urandom_range(1, 12)) begin drive_cycle(0); START = 0; step(); end
                RST_N = 0;
                step();
                RST_N = 1;
            end else begin
                wait_idle(400);
            end
        end
        rmode = 0;
        repeat (3) step();
        chk_eq("final_queue", exp_d.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
